// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: bundles the execute-stage request/response signals and the
// memory-side request/response signals of the load/store unit.
//   master modport : the LSU controller (consumes ex_* and mem_ack/mem_rdata,
//                    drives stall, ld_*, err*, mem_* request signals)
//   slave modport  : the surrounding pipeline and memory model
interface lsu_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 9
);
  localparam int unsigned NB  = DATA_W / 8;
  localparam int unsigned OFS = $clog2(NB);

  // execute-stage request
  logic              ex_valid;
  logic              ex_re;
  logic              ex_we;
  logic [ADDR_W-1:0] ex_addr;
  logic [DATA_W-1:0] ex_wdata;
  logic [1:0]        ex_size;
  logic              ex_unsigned;

  // pipeline-facing results
  logic              stall;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              err;
  logic [1:0]        err_code;

  // memory port
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-OFS-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [NB-1:0]         mem_be;
  logic                  mem_ack;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    input  ex_valid, ex_re, ex_we, ex_addr, ex_wdata, ex_size, ex_unsigned,
    output stall, ld_valid, ld_data, err, err_code,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    output ex_valid, ex_re, ex_we, ex_addr, ex_wdata, ex_size, ex_unsigned,
    input  stall, ld_valid, ld_data, err, err_code,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store controller between the memory
// stage of the pipeline and a word-addressed memory with byte enables.
// Ports:
//   clk   - single clock, rising edge
//   nrst  - asynchronous active-low reset
//   bus   - lsu_ctrl_if.master: ex_* request in; stall, ld_valid/ld_data,
//           err/err_code out; mem_req/we/addr/wdata/be out, mem_ack/rdata in
// stall and err are combinational (they answer the request in its own cycle);
// the mem_* request signals are decoded from captured registers and the state.
module lsu_ctrl #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       nrst,
  lsu_ctrl_if.master bus
);

  localparam int unsigned NB        = DATA_W / 8;
  localparam int unsigned OFS       = $clog2(NB);
  localparam int unsigned WA_W      = ADDR_W - OFS;
  localparam bit          HAS_DWORD = (DATA_W == 64);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  // captured operation
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              we_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] ld_data_q;
  logic [7:0]        wait_cnt_q;

  // request decode
  logic op_c;
  logic illegal_c;
  logic misalign_c;

  // FSM outputs
  logic       accept_c;
  logic       ack_c;
  logic       stall_c;
  logic       err_c;
  logic [1:0] err_code_c;
  logic       mem_req_c;
  logic       ld_valid_c;
  logic       timed_out_c;

  // lane datapath
  logic [OFS-1:0]    off_c;
  int unsigned       sz_mask_c;
  logic [NB-1:0]     be_base_c;
  logic [NB-1:0]     be_c;
  logic [DATA_W-1:0] wrep_c;
  logic [DATA_W-1:0] shifted_c;
  logic              sgn_c;
  logic [DATA_W-1:0] ld_ext_c;

  // Request classification; held inactive while in reset so stall/err stay 0.
  always_comb begin
    op_c       = nrst && bus.ex_valid && (bus.ex_re || bus.ex_we);
    illegal_c  = (bus.ex_re && bus.ex_we) || ((bus.ex_size == 2'd3) && !HAS_DWORD);
    misalign_c = 1'b0;
    case (bus.ex_size)
      2'd0:    misalign_c = 1'b0;
      2'd1:    misalign_c = bus.ex_addr[0];
      2'd2:    misalign_c = |bus.ex_addr[1:0];
      default: misalign_c = |bus.ex_addr[2:0];
    endcase
  end

  // A counter value of MAX_WAIT is only reachable through the no-ack path,
  // so in DONE it marks a timed-out transfer.
  assign timed_out_c = (wait_cnt_q == 8'(MAX_WAIT));

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and control outputs
  always_comb begin
    state_d    = state_q;
    accept_c   = 1'b0;
    ack_c      = 1'b0;
    stall_c    = 1'b0;
    err_c      = 1'b0;
    err_code_c = 2'b00;
    mem_req_c  = 1'b0;
    ld_valid_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op_c) begin
          if (illegal_c) begin
            err_c      = 1'b1;
            err_code_c = 2'b11;
          end else if (misalign_c) begin
            err_c      = 1'b1;
            err_code_c = 2'b01;
          end else begin
            accept_c = 1'b1;
            stall_c  = 1'b1;
            state_d  = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        stall_c   = 1'b1;
        mem_req_c = 1'b1;
        // ack on the final allowed cycle still wins over the timeout
        if (bus.mem_ack) begin
          ack_c   = 1'b1;
          state_d = ST_DONE;
        end else if (wait_cnt_q == 8'(MAX_WAIT - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (timed_out_c) begin
          err_c      = 1'b1;
          err_code_c = 2'b10;
        end else begin
          ld_valid_c = !we_q;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operation capture, wait counter and load result
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      addr_q     <= '0;
      size_q     <= 2'd0;
      uns_q      <= 1'b0;
      we_q       <= 1'b0;
      data_q     <= '0;
      wait_cnt_q <= 8'd0;
      ld_data_q  <= '0;
    end else begin
      if (accept_c) begin
        addr_q     <= bus.ex_addr;
        size_q     <= bus.ex_size;
        uns_q      <= bus.ex_unsigned;
        we_q       <= bus.ex_we;
        data_q     <= bus.ex_wdata;
        wait_cnt_q <= 8'd0;
      end else if ((state_q == ST_BUSY) && !bus.mem_ack) begin
        wait_cnt_q <= wait_cnt_q + 8'd1;
      end
      if (ack_c && !we_q) begin
        ld_data_q <= ld_ext_c;
      end
    end
  end

  // Byte-lane steering: enables, store replication, load alignment/extension.
  // sz_mask_c is (access bytes - 1).
  always_comb begin
    off_c     = addr_q[OFS-1:0];
    sz_mask_c = (32'd1 << size_q) - 32'd1;
    be_base_c = '0;
    wrep_c    = '0;
    ld_ext_c  = '0;
    sgn_c     = 1'b0;
    shifted_c = bus.mem_rdata >> {off_c, 3'b000};
    for (int unsigned i = 0; i < NB; i++) begin
      be_base_c[i]     = (i <= sz_mask_c);
      wrep_c[8*i +: 8] = data_q[8*(i & sz_mask_c) +: 8];
      if (i == sz_mask_c) sgn_c = shifted_c[8*i+7];
    end
    for (int unsigned i = 0; i < NB; i++) begin
      ld_ext_c[8*i +: 8] = (i <= sz_mask_c) ? shifted_c[8*i +: 8]
                                            : {8{sgn_c & ~uns_q}};
    end
    be_c = be_base_c << off_c;
  end

  assign bus.stall     = stall_c;
  assign bus.err       = err_c;
  assign bus.err_code  = err_code_c;
  assign bus.ld_valid  = ld_valid_c;
  assign bus.ld_data   = ld_data_q;
  assign bus.mem_req   = mem_req_c;
  // request fields read as zero outside BUSY
  assign bus.mem_we    = mem_req_c & we_q;
  assign bus.mem_addr  = mem_req_c ? addr_q[ADDR_W-1:OFS] : WA_W'(0);
  assign bus.mem_be    = mem_req_c ? be_c : NB'(0);
  assign bus.mem_wdata = mem_req_c ? wrep_c : DATA_W'(0);

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  lsu_ctrl_if #(.DATA_W(32), .ADDR_W(9)) b32 ();
  lsu_ctrl_if #(.DATA_W(64), .ADDR_W(9)) b64 ();

  lsu_ctrl #(.DATA_W(32), .ADDR_W(9), .MAX_WAIT(4)) u32 (
    .clk (clk),
    .nrst(nrst),
    .bus (b32.master)
  );

  lsu_ctrl #(.DATA_W(64), .ADDR_W(9), .MAX_WAIT(15)) u64 (
    .clk (clk),
    .nrst(nrst),
    .bus (b64.master)
  );

  int nvec = 0;
  int nmis = 0;
  logic [31:0] last_ld32;

  typedef struct {
    logic        re;
    logic        we;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] rdata;
    int          dly;      // ack arrives this many cycles after acceptance
    logic [1:0]  e_code;   // 0: success (or no-op when re=we=0)
    logic [3:0]  e_be;
    logic [6:0]  e_maddr;
    logic [31:0] e_wdata;
    logic [31:0] e_ld;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run32(input vec_t v, input int idx);
    bit is_ld;
    is_ld = v.re && !v.we;
    @(negedge clk);
    b32.ex_valid = 1'b1; b32.ex_re = v.re; b32.ex_we = v.we;
    b32.ex_addr = v.addr; b32.ex_wdata = v.wdata; b32.ex_size = v.size;
    b32.ex_unsigned = v.uns; b32.mem_ack = 1'b0; b32.mem_rdata = v.rdata;
    #1;
    if (!v.re && !v.we) begin
      chk($sformatf("v%0d noop stall", idx), b32.stall, 0);
      chk($sformatf("v%0d noop err", idx), b32.err, 0);
      chk($sformatf("v%0d noop req", idx), b32.mem_req, 0);
    end else if (v.e_code != 2'd0) begin
      chk($sformatf("v%0d err", idx), b32.err, 1);
      chk($sformatf("v%0d err_code", idx), b32.err_code, v.e_code);
      chk($sformatf("v%0d rej stall", idx), b32.stall, 0);
      chk($sformatf("v%0d rej req", idx), b32.mem_req, 0);
    end else begin
      chk($sformatf("v%0d acc stall", idx), b32.stall, 1);
      chk($sformatf("v%0d acc err", idx), b32.err, 0);
      chk($sformatf("v%0d acc req", idx), b32.mem_req, 0);
      for (int k = 1; k <= v.dly; k++) begin
        @(negedge clk);
        b32.ex_valid = 1'b0;
        b32.mem_ack  = (k == v.dly);
        #1;
        chk($sformatf("v%0d busy%0d req", idx, k), b32.mem_req, 1);
        chk($sformatf("v%0d busy%0d stall", idx, k), b32.stall, 1);
        if (k == 1) begin
          chk($sformatf("v%0d be", idx), b32.mem_be, v.e_be);
          chk($sformatf("v%0d maddr", idx), b32.mem_addr, v.e_maddr);
          chk($sformatf("v%0d wdata", idx), b32.mem_wdata, v.e_wdata);
          chk($sformatf("v%0d mem_we", idx), b32.mem_we, v.we);
        end
      end
      // DONE: present the same op again; it must be ignored
      @(negedge clk);
      b32.mem_ack  = 1'b0;
      b32.ex_valid = 1'b1;
      #1;
      chk($sformatf("v%0d done req", idx), b32.mem_req, 0);
      chk($sformatf("v%0d done stall", idx), b32.stall, 0);
      chk($sformatf("v%0d done err", idx), b32.err, 0);
      chk($sformatf("v%0d ld_valid", idx), b32.ld_valid, is_ld);
      chk($sformatf("v%0d ld_data", idx), b32.ld_data, is_ld ? v.e_ld : last_ld32);
      if (is_ld) last_ld32 = v.e_ld;
    end
    @(negedge clk);
    b32.ex_valid = 1'b0;
    b32.mem_ack  = 1'b0;
    #1;
    chk($sformatf("v%0d idle ld_valid", idx), b32.ld_valid, 0);
    chk($sformatf("v%0d idle err", idx), b32.err, 0);
    chk($sformatf("v%0d idle req", idx), b32.mem_req, 0);
  endtask

  task automatic run64(input logic [8:0] addr, input logic [1:0] size, input logic uns,
                       input logic [63:0] rdata, input logic [7:0] e_be,
                       input logic [5:0] e_maddr, input logic [63:0] e_ld, input string tag);
    @(negedge clk);
    b64.ex_valid = 1'b1; b64.ex_re = 1'b1; b64.ex_we = 1'b0; b64.ex_addr = addr;
    b64.ex_size = size; b64.ex_unsigned = uns; b64.mem_rdata = rdata; b64.mem_ack = 1'b0;
    #1;
    chk({tag, " stall"}, b64.stall, 1);
    @(negedge clk);
    b64.ex_valid = 1'b0; b64.mem_ack = 1'b1;
    #1;
    chk({tag, " req"}, b64.mem_req, 1);
    chk({tag, " be"}, b64.mem_be, e_be);
    chk({tag, " maddr"}, b64.mem_addr, e_maddr);
    @(negedge clk);
    b64.mem_ack = 1'b0;
    #1;
    chk({tag, " ld_valid"}, b64.ld_valid, 1);
    chk({tag, " ld_data"}, b64.ld_data, e_ld);
    @(negedge clk);
    #1;
    chk({tag, " idle ld_valid"}, b64.ld_valid, 0);
  endtask

  initial begin
    //          re    we    addr    wdata         sz    uns   rdata         dly code  be       maddr  wdata_exp     ld
    vt[0]  = '{1'b1, 1'b0, 9'h0A2, 32'h0,        2'd0, 1'b0, 32'h80FF0000, 1, 2'd0, 4'b0100, 7'h28, 32'h0,        32'hFFFFFFFF};
    vt[1]  = '{1'b1, 1'b0, 9'h0A3, 32'h0,        2'd0, 1'b0, 32'h80FF0000, 1, 2'd0, 4'b1000, 7'h28, 32'h0,        32'hFFFFFF80};
    vt[2]  = '{1'b0, 1'b1, 9'h006, 32'h1234ABCD, 2'd1, 1'b0, 32'h0,        3, 2'd0, 4'b1100, 7'h01, 32'hABCDABCD, 32'h0};
    vt[3]  = '{1'b1, 1'b0, 9'h005, 32'h0,        2'd2, 1'b0, 32'h0,        0, 2'd1, 4'b0000, 7'h00, 32'h0,        32'h0};
    vt[4]  = '{1'b1, 1'b0, 9'h010, 32'h0,        2'd2, 1'b0, 32'h12345678, 4, 2'd0, 4'b1111, 7'h04, 32'h0,        32'h12345678};
    vt[5]  = '{1'b1, 1'b0, 9'h102, 32'h0,        2'd1, 1'b1, 32'h80017FFF, 1, 2'd0, 4'b1100, 7'h40, 32'h0,        32'h00008001};
    vt[6]  = '{1'b1, 1'b0, 9'h0FE, 32'h0,        2'd1, 1'b0, 32'hFEDC0000, 2, 2'd0, 4'b1100, 7'h3F, 32'h0,        32'hFFFFFEDC};
    vt[7]  = '{1'b0, 1'b1, 9'h1FF, 32'hDEADBE5A, 2'd0, 1'b0, 32'h0,        1, 2'd0, 4'b1000, 7'h7F, 32'h5A5A5A5A, 32'h0};
    vt[8]  = '{1'b0, 1'b1, 9'h004, 32'hCAFEF00D, 2'd2, 1'b0, 32'h0,        2, 2'd0, 4'b1111, 7'h01, 32'hCAFEF00D, 32'h0};
    vt[9]  = '{1'b1, 1'b0, 9'h001, 32'hFFFFFFFF, 2'd0, 1'b1, 32'h00009C00, 1, 2'd0, 4'b0010, 7'h00, 32'hFFFFFFFF, 32'h0000009C};
    vt[10] = '{1'b1, 1'b1, 9'h004, 32'h0,        2'd2, 1'b0, 32'h0,        0, 2'd3, 4'b0000, 7'h00, 32'h0,        32'h0};
    vt[11] = '{1'b1, 1'b0, 9'h000, 32'h0,        2'd3, 1'b0, 32'h0,        0, 2'd3, 4'b0000, 7'h00, 32'h0,        32'h0};
    vt[12] = '{1'b0, 1'b1, 9'h003, 32'h0,        2'd1, 1'b0, 32'h0,        0, 2'd1, 4'b0000, 7'h00, 32'h0,        32'h0};
    vt[13] = '{1'b0, 1'b0, 9'h040, 32'h0,        2'd2, 1'b0, 32'h0,        0, 2'd0, 4'b0000, 7'h00, 32'h0,        32'h0};

    b32.ex_valid = 1'b0; b32.ex_re = 1'b0; b32.ex_we = 1'b0; b32.ex_addr = '0;
    b32.ex_wdata = '0; b32.ex_size = 2'd0; b32.ex_unsigned = 1'b0;
    b32.mem_ack = 1'b0; b32.mem_rdata = '0;
    b64.ex_valid = 1'b0; b64.ex_re = 1'b0; b64.ex_we = 1'b0; b64.ex_addr = '0;
    b64.ex_wdata = '0; b64.ex_size = 2'd0; b64.ex_unsigned = 1'b0;
    b64.mem_ack = 1'b0; b64.mem_rdata = '0;
    last_ld32 = 32'h0;

    // reset state
    nrst = 1'b1;
    #2 nrst = 1'b0;
    #5;
    chk("rst stall", b32.stall, 0);
    chk("rst mem_req", b32.mem_req, 0);
    chk("rst err", {b32.err, b32.err_code}, 0);
    chk("rst mem_be", b32.mem_be, 0);
    chk("rst ld_data", b32.ld_data, 0);
    chk("rst ld_valid", b32.ld_valid, 0);
    chk("rst mem_wdata", b32.mem_wdata, 0);
    @(negedge clk);
    nrst = 1'b1;

    for (int i = 0; i < 14; i++) run32(vt[i], i);

    // timeout: no ack for MAX_WAIT=4 BUSY cycles
    @(negedge clk);
    b32.ex_valid = 1'b1; b32.ex_re = 1'b1; b32.ex_we = 1'b0; b32.ex_addr = 9'h008;
    b32.ex_size = 2'd2; b32.mem_ack = 1'b0;
    #1;
    chk("to accept stall", b32.stall, 1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      b32.ex_valid = 1'b0;
      #1;
      chk($sformatf("to busy%0d req", k), b32.mem_req, 1);
      chk($sformatf("to busy%0d err", k), b32.err, 0);
    end
    @(negedge clk);
    #1;
    chk("to done req", b32.mem_req, 0);
    chk("to done err", b32.err, 1);
    chk("to done code", b32.err_code, 2'b10);
    chk("to done ld_valid", b32.ld_valid, 0);
    chk("to done stall", b32.stall, 0);
    chk("to ld_data hold", b32.ld_data, last_ld32);
    // back in IDLE: a misaligned request is answered immediately
    @(negedge clk);
    b32.ex_valid = 1'b1; b32.ex_addr = 9'h001; b32.ex_size = 2'd2;
    #1;
    chk("to idle err", b32.err, 1);
    chk("to idle code", b32.err_code, 2'b01);
    // ack while IDLE is ignored
    @(negedge clk);
    b32.ex_valid = 1'b0; b32.mem_ack = 1'b1;
    #1;
    chk("idle ack req", b32.mem_req, 0);
    chk("idle ack err", b32.err, 0);
    @(negedge clk);
    b32.mem_ack = 1'b0;
    #1;
    chk("idle ack ld_valid", b32.ld_valid, 0);
    chk("idle ack stall", b32.stall, 0);

    // reset in the middle of BUSY
    @(negedge clk);
    b32.ex_valid = 1'b1; b32.ex_re = 1'b1; b32.ex_we = 1'b0; b32.ex_addr = 9'h0A2;
    b32.ex_size = 2'd0; b32.mem_ack = 1'b0;
    @(negedge clk);
    b32.ex_valid = 1'b0;
    #1;
    chk("rb busy req", b32.mem_req, 1);
    #2 nrst = 1'b0;
    #1;
    chk("rb req", b32.mem_req, 0);
    chk("rb stall", b32.stall, 0);
    chk("rb be", b32.mem_be, 0);
    chk("rb ld_data", b32.ld_data, 0);
    @(negedge clk);
    nrst = 1'b1;
    last_ld32 = 32'h0;
    run32(vt[2], 102);
    run32(vt[5], 105);

    // 64-bit datapath
    run64(9'h010, 2'd3, 1'b1, 64'h8877665544332211, 8'hFF, 6'd2,
          64'h8877665544332211, "d64 dword");
    run64(9'h01C, 2'd2, 1'b0, 64'h8000000100000000, 8'hF0, 6'd3,
          64'hFFFFFFFF80000001, "d64 word");
    run64(9'h00F, 2'd0, 1'b1, 64'hAB00000000000000, 8'h80, 6'd1,
          64'h00000000000000AB, "d64 byte");
    @(negedge clk);
    b64.ex_valid = 1'b1; b64.ex_re = 1'b1; b64.ex_addr = 9'h014; b64.ex_size = 2'd3;
    #1;
    chk("d64 mis err", b64.err, 1);
    chk("d64 mis code", b64.err_code, 2'b01);
    chk("d64 mis stall", b64.stall, 0);
    @(negedge clk);
    b64.ex_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
